// File: rtl/uart_baud_gen_ovs.sv
// uart_baud_gen_ovs: oversample/mid-bit/bit-boundary tick generator with integer+fractional divisor.
// Define UART_BAUD_FRAC_EN to include the fractional phase accumulator; otherwise Div_frac is ignored.
module uart_baud_gen_ovs #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              ovs_tick_o,
  output logic              mid_tick_o,
  output logic              bit_tick_o,
  output logic              div_err_o
);
  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] LAST = OW'(OVS - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [OW-1:0]    ovs_cnt_q, ovs_cnt_d;
  logic             err_q, err_d, ovs_q, ovs_d, mid_q, mid_d, bit_q, bit_d;
  logic [CNT_W:0]   per_m1;
  logic             extra, run, hit, last, load;
  // One extra bit of width keeps div_q = all-ones plus a carry period representable.
  always_comb begin
    run       = en_i & ~restart_i;
    per_m1    = {1'b0, div_q} + (CNT_W+1)'(extra) - (CNT_W+1)'(1);
    hit       = run & ({1'b0, cnt_q} == per_m1);
    last      = hit & (ovs_cnt_q == LAST);
    load      = restart_i | ~en_i | last;
    div_d     = load ? (div_int_i < CNT_W'(2) ? CNT_W'(2) : div_int_i) : div_q;
    err_d     = load ? (div_int_i < CNT_W'(2)) : err_q;
    cnt_d     = restart_i ? '0 : !en_i ? cnt_q : hit ? '0 : cnt_q + CNT_W'(1);
    ovs_cnt_d = restart_i ? '0 : !hit ? ovs_cnt_q : last ? '0 : ovs_cnt_q + OW'(1);
    ovs_d     = hit;
    mid_d     = hit & (ovs_cnt_q == MID);
    bit_d     = last;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      ovs_cnt_q <= '0;
      div_q     <= CNT_W'(2);
      err_q     <= 1'b0;
      ovs_q     <= 1'b0;
      mid_q     <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovs_cnt_q <= ovs_cnt_d;
      div_q     <= div_d;
      err_q     <= err_d;
      ovs_q     <= ovs_d;
      mid_q     <= mid_d;
      bit_q     <= bit_d;
    end
  end
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d, frac_q, frac_d;
  logic              extra_q, extra_d;
  // The carry out of the accumulator stretches the following oversample period by one cycle.
  always_comb begin
    {extra_d, acc_d} = restart_i ? '0 : hit ? {1'b0, acc_q} + {1'b0, frac_q} : {extra_q, acc_q};
    frac_d           = load ? div_frac_i : frac_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      frac_q  <= '0;
      extra_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      frac_q  <= frac_d;
      extra_q <= extra_d;
    end
  end
  assign extra = extra_q;
`else
  logic unused_frac;
  assign unused_frac = ^div_frac_i;
  assign extra       = 1'b0;
`endif
  assign ovs_tick_o = ovs_q;
  assign mid_tick_o = mid_q;
  assign bit_tick_o = bit_q;
  assign div_err_o  = err_q;
endmodule

// File: tb/tb_uart_baud_gen_ovs.sv
// tb_uart_baud_gen_ovs: randomized and directed checks of the baud generator against a tick-time model.
// The model tracks enabled-edge counts and tick timestamps rather than the design's counters.
module tb_uart_baud_gen_ovs;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, restart = 1'b0;
  logic [15:0] div_int = 16'd4;
  logic [3:0]  div_frac = 4'd0;
  logic        ovs_tick, mid_tick, bit_tick, div_err;
  wire  [3:0]  obs = {ovs_tick, mid_tick, bit_tick, div_err};
  int checks = 0, failures = 0;
  int m_e, m_last, m_k, m_acc, m_extra, m_d, m_f, m_err;
  logic [3:0] exp_v;

  uart_baud_gen_ovs dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .div_int_i(div_int), .div_frac_i(div_frac),
    .ovs_tick_o(ovs_tick), .mid_tick_o(mid_tick), .bit_tick_o(bit_tick), .div_err_o(div_err)
  );

  always #5 clk = ~clk;

  function automatic void load(input int di, input int df);
    m_d   = di < 2 ? 2 : di;
    m_f   = FRAC ? df : 0;
    m_err = di < 2;
  endfunction

  // Drives one edge and updates the expected outputs; ticks are timestamped in enabled edges.
  task automatic cyc(input bit r, input bit e, input bit rs, input int di, input int df);
    bit ov, md, bt;
    rst = r; en = e; restart = rs; div_int = di[15:0]; div_frac = df[3:0];
    @(posedge clk); #1;
    {ov, md, bt} = 3'b000;
    if (r) begin
      m_e = 0; m_last = 0; m_k = 0; m_acc = 0; m_extra = 0; m_d = 2; m_f = 0; m_err = 0;
    end else if (rs) begin
      load(di, df);
      m_e = 0; m_last = 0; m_k = 0; m_acc = 0; m_extra = 0;
    end else if (!e) begin
      load(di, df);
    end else begin
      m_e++;
      if (m_e - m_last == m_d + m_extra) begin
        ov = 1'b1;
        md = (m_k == 7);
        bt = (m_k == 15);
        m_k = (m_k + 1) % 16;
        m_acc += m_f;
        m_extra = m_acc >= 16;
        m_acc %= 16;
        m_last = m_e;
        if (bt) load(di, df);
      end
    end
    exp_v = {ov, md, bt, m_err[0]};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 7, 3);
      checks++;
      if (obs !== 4'b0000) begin failures++; $display("FAIL reset got=%b exp=0000", obs); end
    end
  endtask

  task automatic test_basic();
    int fb = -1, fm = -1, nb = 0;
    cyc(0, 1, 1, 4, 0);
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1, 0, 4, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL basic e=%0d got=%b exp=%b", m_e, obs, exp_v); end
      if (bit_tick && fb < 0) fb = m_e;
      if (mid_tick && fm < 0) fm = m_e;
      nb += bit_tick;
    end
    checks++;
    if (fb !== 64) begin failures++; $display("FAIL basic_first_bit got=%0d exp=64", fb); end
    checks++;
    if (fm !== 32) begin failures++; $display("FAIL basic_first_mid got=%0d exp=32", fm); end
    checks++;
    if (nb !== 3) begin failures++; $display("FAIL basic_bit_count got=%0d exp=3", nb); end
  endtask

  task automatic test_frac();
    int t1 = -1, t17 = -1, n = 0;
    cyc(0, 1, 1, 27, 2);
    for (int i = 0; i < 480; i++) begin
      cyc(0, 1, 0, 27, 2);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL frac e=%0d got=%b exp=%b", m_e, obs, exp_v); end
      if (ovs_tick) begin
        n++;
        if (n == 1) t1 = m_e;
        if (n == 17) t17 = m_e;
      end
    end
    checks++;
    if (t17 - t1 !== (FRAC ? 434 : 432))
      begin failures++; $display("FAIL frac_span got=%0d exp=%0d", t17 - t1, FRAC ? 434 : 432); end
  endtask

  task automatic test_div_change();
    int n = 0, di = 4, tb = -1, ta = -1, tp = -1;
    cyc(0, 1, 1, 4, 0);
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1, 0, di, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL divchg e=%0d got=%b exp=%b", m_e, obs, exp_v); end
      if (ovs_tick) begin
        n++;
        if (n == 5) di = 8;
        if (n == 15) tp = m_e;
        if (bit_tick && tb < 0) tb = m_e;
        if (n == 17) ta = m_e;
      end
    end
    checks++;
    if (tb - tp !== 4) begin failures++; $display("FAIL divchg_before got=%0d exp=4", tb - tp); end
    checks++;
    if (ta - tb !== 8) begin failures++; $display("FAIL divchg_after got=%0d exp=8", ta - tb); end
  endtask

  task automatic test_restart();
    int t = -1, tb = -1;
    cyc(0, 1, 1, 4, 0);
    for (int i = 0; i < 38; i++) cyc(0, 1, 0, 4, 0);
    cyc(0, 1, 1, 4, 0);
    checks++;
    if (obs !== 4'b0000) begin failures++; $display("FAIL restart_cycle got=%b exp=0000", obs); end
    for (int i = 1; i <= 80; i++) begin
      cyc(0, 1, 0, 4, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL restart e=%0d got=%b exp=%b", m_e, obs, exp_v); end
      if (ovs_tick && t < 0) t = i;
      if (bit_tick && tb < 0) tb = i;
    end
    checks++;
    if (t !== 4) begin failures++; $display("FAIL restart_first got=%0d exp=4", t); end
    checks++;
    if (tb !== 64) begin failures++; $display("FAIL restart_bit got=%0d exp=64", tb); end
  endtask

  task automatic test_div_err();
    int v[3] = '{1, 0, 3};
    for (int j = 0; j < 3; j++) begin
      int p = -1, q = -1;
      cyc(0, 1, 1, v[j], 0);
      checks++;
      if (div_err !== (v[j] < 2)) begin failures++; $display("FAIL diverr_flag div=%0d got=%b", v[j], div_err); end
      for (int i = 1; i <= 20; i++) begin
        cyc(0, 1, 0, v[j], 0);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL diverr e=%0d got=%b exp=%b", m_e, obs, exp_v); end
        if (ovs_tick) begin q = p; p = i; end
      end
      checks++;
      if (p - q !== (v[j] < 2 ? 2 : 3)) begin failures++; $display("FAIL diverr_period div=%0d got=%0d", v[j], p - q); end
    end
  endtask

  task automatic test_rst_mid();
    cyc(0, 1, 1, 4, 0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 0, 4, 0);
    cyc(1, 1, 0, 4, 0);
    checks++;
    if (obs !== 4'b0000) begin failures++; $display("FAIL rst_mid got=%b exp=0000", obs); end
    for (int i = 0; i < 200; i++) begin
      cyc(0, !(i >= 100 && i < 110), 0, 4, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL rst_run i=%0d got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    int di = 5, df = 3;
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 199);
      if (r == 0) cyc(1, 1, 0, di, df);
      else if (r < 6) begin
        di = $urandom_range(0, 9);
        df = $urandom_range(0, 15);
        cyc(0, $urandom_range(0, 1), 1, di, df);
      end else cyc(0, $urandom_range(0, 9) != 0, 0, di, df);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_div_change();
    test_restart();
    test_div_err();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
